// File: rtl/system_sw_poller_pkg.sv
// Shared types and sizing for the switch PIO poller.
package system_sw_poller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2
    } poll_state_e;

    localparam int DEF_POLL_DIV = 50000;
    localparam int TIMER_W      = $clog2(DEF_POLL_DIV);
    localparam int CNT_W        = 8;

    function automatic int timer_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/system_sw_debounce.sv
// Sample debouncer: a value is accepted on the strobe where it has been seen DEBOUNCE times in a row.
module system_sw_debounce
    import system_sw_poller_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             strobe_i,
    input  logic [WIDTH-1:0] sample_i,
    output logic             accept_o,
    output logic [WIDTH-1:0] value_o
);
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE);

    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             same;

    always_comb begin
        cand_d   = cand_q;
        count_d  = count_q;
        accept_o = 1'b0;
        same     = (sample_i == cand_q);
        if (strobe_i) begin
            cand_d = sample_i;
            if (!same) begin
                count_d = CNT_W'(1);
            end else if (count_q != DB_MAX) begin
                count_d = count_q + CNT_W'(1);
            end
            // Fire only on the step into saturation, never while already saturated.
            accept_o = (count_d == DB_MAX) && (!same || (count_q != DB_MAX));
        end
    end

    assign value_o = cand_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cand_q  <= '0;
            count_q <= '0;
        end else begin
            cand_q  <= cand_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/system_sw_poller.sv
// Avalon-MM poller for the switch PIO: periodic reads, debounce, and change events on a valid/ready stream.
module system_sw_poller
    import system_sw_poller_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int POLL_DIV = 50000,
    parameter int DEBOUNCE = 4,
    parameter int PIO_ADDR = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic [31:0]      avm_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_data,
    output logic [WIDTH-1:0] evt_changed,
    output logic             evt_overflow,
    input  logic             ovf_clear,
    output logic [WIDTH-1:0] sw_state
);
    localparam int            TW        = timer_width(POLL_DIV);
    localparam logic [TW-1:0] TIMER_MAX = TW'(POLL_DIV - 1);

    poll_state_e      state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] sw_q, sw_d, data_q, data_d, changed_q, changed_d;
    logic             primed_q, primed_d, valid_q, valid_d, ovf_q, ovf_d;

    logic             accept;
    logic [WIDTH-1:0] acc_value, delta;
    logic             raise, coalesce;

    generate
        if (WIDTH < 32) begin : gen_unused
            logic unused_rdata;
            assign unused_rdata = ^avm_readdata[31:WIDTH];
        end
    endgenerate

    system_sw_debounce #(
        .WIDTH   (WIDTH),
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk_i   (clk),
        .reset_i (reset),
        .strobe_i(state_q == CAPTURE),
        .sample_i(avm_readdata[WIDTH-1:0]),
        .accept_o(accept),
        .value_o (acc_value)
    );

    // The timer free-runs through READ/CAPTURE so the poll period is exactly POLL_DIV.
    always_comb begin
        state_d = state_q;
        timer_d = (timer_q == TIMER_MAX) ? '0 : timer_q + TW'(1);
        unique case (state_q)
            IDLE:    if (timer_q == TIMER_MAX) state_d = READ;
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sw_d      = sw_q;
        primed_d  = primed_q;
        valid_d   = valid_q;
        data_d    = data_q;
        changed_d = changed_q;
        ovf_d     = ovf_q;
        raise     = 1'b0;
        coalesce  = 1'b0;
        delta     = acc_value ^ sw_q;
        if (accept && !primed_q) begin
            sw_d     = acc_value;
            primed_d = 1'b1;
        end else if (accept && (delta != '0)) begin
            sw_d   = acc_value;
            data_d = acc_value;
            if (valid_q && !evt_ready) begin
                coalesce  = 1'b1;
                changed_d = changed_q | delta;
            end else begin
                raise     = 1'b1;
                valid_d   = 1'b1;
                changed_d = delta;
            end
        end
        if (valid_q && evt_ready && !raise) begin
            valid_d   = 1'b0;
            changed_d = '0;
        end
        if (coalesce) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            sw_q      <= '0;
            primed_q  <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            changed_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sw_q      <= sw_d;
            primed_q  <= primed_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            changed_q <= changed_d;
            ovf_q     <= ovf_d;
        end
    end

    assign avm_address  = 2'(PIO_ADDR);
    assign avm_read     = (state_q == READ);
    assign evt_valid    = valid_q;
    assign evt_data     = data_q;
    assign evt_changed  = changed_q;
    assign evt_overflow = ovf_q;
    assign sw_state     = sw_q;

endmodule

// File: tb/tb_system_sw_poller.sv
// Bench for system_sw_poller: directed scenarios plus random polling against a cycle-count based model.
module tb_system_sw_poller;
    localparam int W  = 10;
    localparam int P  = 4;
    localparam int D  = 3;
    localparam int PA = 0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata = '0;
    logic         evt_valid;
    logic         evt_ready = 1'b0;
    logic [W-1:0] evt_data;
    logic [W-1:0] evt_changed;
    logic         evt_overflow;
    logic         ovf_clear = 1'b0;
    logic [W-1:0] sw_state;

    always #5 clk = ~clk;

    system_sw_poller #(
        .WIDTH   (W),
        .POLL_DIV(P),
        .DEBOUNCE(D),
        .PIO_ADDR(PA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .avm_address (avm_address),
        .avm_read    (avm_read),
        .avm_readdata(avm_readdata),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_data    (evt_data),
        .evt_changed (evt_changed),
        .evt_overflow(evt_overflow),
        .ovf_clear   (ovf_clear),
        .sw_state    (sw_state)
    );

    int checks = 0;
    int passes = 0;
    int cycle  = 0;

    // Model: m_n counts clock edges since reset release; samples tracked as a run length.
    int           m_n;
    int           run_len;
    logic [W-1:0] run_val, m_sw, m_data, m_changed;
    logic         m_primed, m_valid, m_ovf, m_cap;

    // Stimulus controls and observations
    logic [W-1:0] sw_in = '0;
    int           rdy_mode = 0;
    logic         rdy_fixed = 1'b0;
    int           clr_mode = 0;
    int           valid_seen, hs_cnt;
    logic [W-1:0] hs_data, hs_changed, prev_data, prev_changed;
    logic         prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    function automatic logic cap_now();
        return (m_n > P) && (m_n % P == 1);
    endfunction

    task automatic model_reset();
        m_n = 0; run_len = 0; run_val = '0; m_sw = '0; m_data = '0; m_changed = '0;
        m_primed = 1'b0; m_valid = 1'b0; m_ovf = 1'b0; m_cap = 1'b0;
    endtask

    task automatic model_step();
        logic [W-1:0] s = '0;
        logic [W-1:0] delta = '0;
        logic raise = 1'b0;
        logic coal = 1'b0;
        logic hs;
        hs = m_valid && evt_ready;
        m_cap = cap_now();
        if (m_cap) begin
            s = avm_readdata[W-1:0];
            if (run_len > 0 && s == run_val) run_len++;
            else begin run_val = s; run_len = 1; end
            if (run_len == D) begin
                if (!m_primed) begin
                    m_sw = s; m_primed = 1'b1;
                end else if (s != m_sw) begin
                    delta = s ^ m_sw; m_sw = s; m_data = s;
                    if (m_valid && !evt_ready) begin
                        coal = 1'b1; m_changed = m_changed | delta; m_ovf = 1'b1;
                    end else begin
                        raise = 1'b1; m_valid = 1'b1; m_changed = delta;
                    end
                end
            end
        end
        if (hs && !raise) begin m_valid = 1'b0; m_changed = '0; end
        if (!coal && ovf_clear) m_ovf = 1'b0;
        m_n++;
    endtask

    task automatic drive();
        avm_readdata = $urandom();
        if (cap_now()) avm_readdata[W-1:0] = sw_in;
        case (rdy_mode)
            0:       evt_ready = rdy_fixed;
            1:       evt_ready = cap_now();
            default: evt_ready = 1'($urandom_range(0, 1));
        endcase
        ovf_clear = (clr_mode != 0) ? ($urandom_range(0, 5) == 0) : 1'b0;
    endtask

    // One clock: model update and full output comparison at the falling edge, then new inputs.
    task automatic tick();
        @(negedge clk);
        cycle++;
        if (reset) model_reset(); else model_step();
        chk("avm_read", 32'(avm_read), 32'(m_n > 0 && m_n % P == 0));
        chk("avm_address", 32'(avm_address), 32'(PA));
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        chk("evt_data", 32'(evt_data), 32'(m_data));
        chk("evt_changed", 32'(evt_changed), 32'(m_changed));
        chk("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
        chk("sw_state", 32'(sw_state), 32'(m_sw));
        if (evt_valid) valid_seen++;
        if (prev_valid && evt_ready && !reset) begin
            hs_cnt++; hs_data = prev_data; hs_changed = prev_changed;
        end
        prev_valid = evt_valid; prev_data = evt_data; prev_changed = evt_changed;
        #1;
        drive();
    endtask

    task automatic poll_one(input logic [W-1:0] v);
        logic done = 1'b0;
        sw_in = v;
        drive();
        for (int i = 0; i < 3 * P && !done; i++) begin
            tick();
            if (m_cap) done = 1'b1;
        end
        chk("poll_done", 32'(done), 32'(1));
    endtask

    task automatic set_ready(input logic b);
        rdy_mode = 0; rdy_fixed = b; drive();
    endtask

    task automatic clear_obs();
        valid_seen = 0; hs_cnt = 0; hs_data = '0; hs_changed = '0;
    endtask

    initial begin
        logic [W-1:0] cur;
        int guard;
        model_reset();
        clear_obs();
        sw_in = 10'h005;
        repeat (3) tick();
        chk("rst_evt_valid", 32'(evt_valid), 32'(0));
        chk("rst_sw_state", 32'(sw_state), 32'(0));
        reset = 1'b0;

        // Scenario 1: silent prime with reads at cycles 4, 8, 12
        clear_obs();
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk("t1_read_slot", 32'(avm_read), 32'(i % P == 0));
        end
        chk("t1_sw_state", 32'(sw_state), 32'(10'h005));
        chk("t1_no_event", 32'(valid_seen), 32'(0));

        // Scenario 2: one clean change
        set_ready(1'b1);
        clear_obs();
        repeat (3) poll_one(10'h105);
        repeat (3) tick();
        chk("t2_events", 32'(hs_cnt), 32'(1));
        chk("t2_data", 32'(hs_data), 32'(10'h105));
        chk("t2_changed", 32'(hs_changed), 32'(10'h100));
        chk("t2_sw_state", 32'(sw_state), 32'(10'h105));

        // Scenario 3: bouncing input then settle
        clear_obs();
        for (int i = 0; i < 10; i++) poll_one((i % 2 == 0) ? 10'h105 : 10'h104);
        repeat (4) poll_one(10'h104);
        repeat (3) tick();
        chk("t3_events", 32'(hs_cnt), 32'(1));
        chk("t3_data", 32'(hs_data), 32'(10'h104));
        chk("t3_changed", 32'(hs_changed), 32'(10'h001));

        // Scenario 4: coalescing with a stalled consumer, then overflow clear
        repeat (3) poll_one(10'h000);
        repeat (2) tick();
        set_ready(1'b0);
        repeat (3) poll_one(10'h001);
        chk("t4_first_valid", 32'(evt_valid), 32'(1));
        chk("t4_first_data", 32'(evt_data), 32'(10'h001));
        repeat (3) poll_one(10'h003);
        tick();
        chk("t4_data", 32'(evt_data), 32'(10'h003));
        chk("t4_changed", 32'(evt_changed), 32'(10'h003));
        chk("t4_ovf", 32'(evt_overflow), 32'(1));
        ovf_clear = 1'b1;
        tick();
        chk("t4_ovf_cleared", 32'(evt_overflow), 32'(0));
        chk("t4_valid_held", 32'(evt_valid), 32'(1));

        // Scenario 5: handshake in the same cycle as a new acceptance
        repeat (2) poll_one(10'h007);
        rdy_mode = 1;
        poll_one(10'h007);
        chk("t5_valid", 32'(evt_valid), 32'(1));
        chk("t5_data", 32'(evt_data), 32'(10'h007));
        chk("t5_changed", 32'(evt_changed), 32'(10'h004));
        chk("t5_ovf", 32'(evt_overflow), 32'(0));
        set_ready(1'b1);
        repeat (2) tick();

        // Scenario 6: asynchronous reset during READ with an event pending
        set_ready(1'b0);
        repeat (3) poll_one(10'h0F0);
        guard = 0;
        while (!(m_n > 0 && m_n % P == 0) && guard < 2 * P) begin
            tick();
            guard++;
        end
        chk("t6_in_read", 32'(avm_read), 32'(1));
        chk("t6_pending", 32'(evt_valid), 32'(1));
        reset = 1'b1;
        #1;
        chk("t6_rst_read", 32'(avm_read), 32'(0));
        chk("t6_rst_valid", 32'(evt_valid), 32'(0));
        chk("t6_rst_data", 32'(evt_data), 32'(0));
        chk("t6_rst_changed", 32'(evt_changed), 32'(0));
        chk("t6_rst_sw_state", 32'(sw_state), 32'(0));
        repeat (2) tick();
        reset = 1'b0;
        for (int i = 1; i <= P + 1; i++) begin
            tick();
            chk("t6_read_slot", 32'(avm_read), 32'(i == P));
        end
        set_ready(1'b1);
        clear_obs();
        repeat (3) poll_one(10'h0F0);
        repeat (2) tick();
        chk("t6_prime_silent", 32'(valid_seen), 32'(0));
        chk("t6_prime_state", 32'(sw_state), 32'(10'h0F0));

        // Random phase: sticky-ish switch values, random ready and overflow clears
        rdy_mode = 2;
        clr_mode = 1;
        cur = sw_state;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) cur = W'($urandom());
            poll_one(cur);
        end
        repeat (4) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
